// File: rtl/noc_pkt_buf_pkg.sv
// Shared definitions for the NoC store-and-forward packet buffer: FSM state
// encodings and the position of the header payload-length field.
package noc_pkt_buf_pkg;

    localparam int LEN_LSB = 22;
    localparam int LEN_MSB = 29;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    typedef enum logic {
        IN_HDR  = 1'b0,
        IN_BODY = 1'b1
    } in_state_t;

    typedef enum logic {
        OUT_HDR  = 1'b0,
        OUT_BODY = 1'b1
    } out_state_t;

endpackage

// File: rtl/noc_pkt_fifo_mem.sv
// Flit storage for the packet buffer: DEPTH x DATA_W, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module noc_pkt_fifo_mem
    import noc_pkt_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/noc_pkt_store_fwd.sv
// Store-and-forward NoC packet buffer with cut-through fallback for packets
// longer than the buffer. Optional statistics: NOC_PKT_STORE_FWD_STATS_EN.
module noc_pkt_store_fwd
    import noc_pkt_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic              core_ref_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_val,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic              oversize_err,
    output logic [31:0]       pkt_cnt_total
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr, occ;
    logic [PW-1:0]    pkt_cnt;
    logic             run;
    logic             wr_en, rd_en, empty, full;
    logic [LEN_W-1:0] in_len, out_len;
    logic             head_oversize;

    in_state_t        in_state, in_state_nxt;
    logic [LEN_W-1:0] in_rem, in_rem_nxt;
    logic             wr_last, in_oversize;

    out_state_t       out_state, out_state_nxt;
    logic [LEN_W-1:0] out_rem, out_rem_nxt;
    logic             rd_last, ct_mode, ct_mode_nxt;

    function automatic logic is_oversize(input logic [LEN_W-1:0] len);
        return (int'(len) + 1) > DEPTH;
    endfunction

    // Occupancy never exceeds DEPTH, so its MSB alone marks full.
    assign occ    = wr_ptr - rd_ptr;
    assign empty  = (occ == '0);
    assign full   = occ[AW];
    assign in_rdy = run & ~full;
    assign wr_en  = in_val & in_rdy;
    assign rd_en  = out_val & out_rdy;

    assign in_len        = in_data[LEN_MSB:LEN_LSB];
    assign out_len       = out_data[LEN_MSB:LEN_LSB];
    assign head_oversize = is_oversize(out_len);

    noc_pkt_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (core_ref_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (out_data)
    );

    // An oversize header at the head must not wait for completion, or the
    // buffer would fill before the packet ever counts as stored.
    always_comb begin
        out_val = 1'b0;
        if (!empty) begin
            if (out_state == OUT_BODY) begin
                out_val = ct_mode || (pkt_cnt != '0);
            end else begin
                out_val = head_oversize || (pkt_cnt != '0);
            end
        end
    end

    always_comb begin
        in_state_nxt = in_state;
        in_rem_nxt   = in_rem;
        wr_last      = 1'b0;
        in_oversize  = 1'b0;
        if (wr_en) begin
            if (in_state == IN_HDR) begin
                in_oversize = is_oversize(in_len);
                if (in_len == '0) begin
                    wr_last = 1'b1;
                end else begin
                    in_state_nxt = IN_BODY;
                    in_rem_nxt   = in_len;
                end
            end else begin
                in_rem_nxt = in_rem - LEN_W'(1);
                if (in_rem == LEN_W'(1)) begin
                    wr_last      = 1'b1;
                    in_state_nxt = IN_HDR;
                end
            end
        end
    end

    always_comb begin
        out_state_nxt = out_state;
        out_rem_nxt   = out_rem;
        ct_mode_nxt   = ct_mode;
        rd_last       = 1'b0;
        if (rd_en) begin
            if (out_state == OUT_HDR) begin
                if (out_len == '0) begin
                    rd_last = 1'b1;
                end else begin
                    out_state_nxt = OUT_BODY;
                    out_rem_nxt   = out_len;
                    ct_mode_nxt   = head_oversize;
                end
            end else begin
                out_rem_nxt = out_rem - LEN_W'(1);
                if (out_rem == LEN_W'(1)) begin
                    rd_last       = 1'b1;
                    out_state_nxt = OUT_HDR;
                    ct_mode_nxt   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge core_ref_clk) begin
        if (!sys_rst_n) begin
            run          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pkt_cnt      <= '0;
            in_state     <= IN_HDR;
            in_rem       <= '0;
            out_state    <= OUT_HDR;
            out_rem      <= '0;
            ct_mode      <= 1'b0;
            oversize_err <= 1'b0;
        end else begin
            run       <= 1'b1;
            in_state  <= in_state_nxt;
            in_rem    <= in_rem_nxt;
            out_state <= out_state_nxt;
            out_rem   <= out_rem_nxt;
            ct_mode   <= ct_mode_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_last && !rd_last) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end else if (!wr_last && rd_last) begin
                pkt_cnt <= pkt_cnt - PW'(1);
            end
            if (in_oversize) begin
                oversize_err <= 1'b1;
            end
        end
    end

`ifdef NOC_PKT_STORE_FWD_STATS_EN
    logic [31:0] total_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge core_ref_clk) begin
        if (!sys_rst_n) begin
            total_cnt <= '0;
        end else if (rd_last) begin
            total_cnt <= sat_inc(total_cnt);
        end
    end

    assign pkt_cnt_total = total_cnt;
`else
    assign pkt_cnt_total = '0;
`endif

endmodule
